// File: rtl/gpr_writeback_arbiter_pkg.sv
// Shared types for the GPR writeback path: register index and the
// secondary-result entry that is queued until the write port is free.
package gpr_wb_pkg;

  localparam int DW = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [DW-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/gpr_writeback_arbiter_if.sv
// Bundle of result streams, scoreboard ports and the GPR write port.
// slave: the arbiter side; master: execute/memory/decode/GPR side.
interface gpr_writeback_arbiter_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  import gpr_wb_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic            PriValid;
  logic            PriReady;
  reg_idx_t        PriReg;
  logic [DW-1:0]   PriData;
  logic            SecValid;
  logic            SecReady;
  reg_idx_t        SecReg;
  logic [DW-1:0]   SecData;
  logic            IssueValid;
  reg_idx_t        IssueReg;
  reg_idx_t        ReadRegister1;
  reg_idx_t        ReadRegister2;
  logic            Hazard;
  logic            RegWrite;
  reg_idx_t        WriteRegisterSelect;
  logic [DW-1:0]   WriteData;
  logic [CW-1:0]   FifoCount;

  modport slave (
    input  PriValid, PriReg, PriData,
    input  SecValid, SecReg, SecData,
    input  IssueValid, IssueReg,
    input  ReadRegister1, ReadRegister2,
    output PriReady, SecReady, Hazard,
    output RegWrite, WriteRegisterSelect, WriteData, FifoCount
  );

  modport master (
    output PriValid, PriReg, PriData,
    output SecValid, SecReg, SecData,
    output IssueValid, IssueReg,
    output ReadRegister1, ReadRegister2,
    input  PriReady, SecReady, Hazard,
    input  RegWrite, WriteRegisterSelect, WriteData, FifoCount
  );

endinterface

// File: rtl/gpr_writeback_arbiter_fifo.sv
// Small circular FIFO holding secondary (mul/div) results until the
// write port is free. Head is read straight from storage (no bypass), so
// an entry is visible at the head the cycle after it is pushed.
module wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  wb_entry_t                    push_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output wb_entry_t                    head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  // Entry storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Owns the single GPR write port. Primary (ALU/load) results win by
// default; queued secondary (mul/div) results fill idle slots, and a
// starve counter forces one secondary slot after STARVE primary wins.
// A per-register busy mask lets decode stall on outstanding mul/div.
module gpr_writeback_arbiter
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DW     = gpr_wb_pkg::DW,
  parameter int STARVE = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  gpr_writeback_arbiter_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE + 1);

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  wb_entry_t         fifo_head;
  wb_entry_t         push_entry;

  logic              sec_ready;
  logic              pri_ready;
  logic              pri_sel;
  logic              push;
  logic              pop;

  logic [SW-1:0]     starve_cnt;
  logic [31:0]       busy;
  logic [31:0]       busy_set;
  logic [31:0]       busy_clr;

  logic              vld_p1;
  reg_idx_t          wr_reg_p1;
  logic [DW-1:0]     wr_data_p1;

  // Primary is held off only in the single cycle the counter sits at STARVE;
  // the FIFO is guaranteed non-empty then, so that slot always pops.
  assign pri_ready  = (starve_cnt != SW'(STARVE));
  assign pri_sel    = bus.PriValid && pri_ready;
  assign pop        = !pri_sel && !fifo_empty;
  assign sec_ready  = !fifo_full && !RST;
  assign push       = bus.SecValid && sec_ready;
  assign push_entry = '{rd: bus.SecReg, data: bus.SecData};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Starve counter: counts primary wins only while secondary work waits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (pri_sel) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // One-hot set/clear requests for the busy mask this cycle.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (bus.IssueValid) busy_set[bus.IssueReg] = 1'b1;
    if (pop)            busy_clr[fifo_head.rd] = 1'b1;
  end

  // Busy mask: set beats clear on the same register; r0 never busy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~busy_clr) | busy_set) & ~32'd1;
    end
  end

  // ---- stage p0 -> p1: registered GPR write port ----
  // Destination r0 still consumes the slot but never asserts the enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1     <= 1'b0;
      wr_reg_p1  <= '0;
      wr_data_p1 <= '0;
    end else if (pri_sel) begin
      vld_p1     <= (bus.PriReg != '0);
      wr_reg_p1  <= bus.PriReg;
      wr_data_p1 <= bus.PriData;
    end else if (pop) begin
      vld_p1     <= (fifo_head.rd != '0);
      wr_reg_p1  <= fifo_head.rd;
      wr_data_p1 <= fifo_head.data;
    end else begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.PriReady            = pri_ready;
  assign bus.SecReady            = sec_ready;
  assign bus.Hazard              = busy[bus.ReadRegister1] | busy[bus.ReadRegister2];
  assign bus.RegWrite            = vld_p1;
  assign bus.WriteRegisterSelect = wr_reg_p1;
  assign bus.WriteData           = wr_data_p1;
  assign bus.FifoCount           = fifo_count;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed bench for gpr_writeback_arbiter with a queue-based reference
// model checked every cycle plus literal expectations per scenario.
module tb_gpr_writeback_arbiter;
  import gpr_wb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic CLK;
  logic RST;

  gpr_writeback_arbiter_if #(.DW(32), .DEPTH(DEPTH)) bus ();

  gpr_writeback_arbiter #(
    .DEPTH  (DEPTH),
    .DW     (32),
    .STARVE (STARVE)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model state
  wb_entry_t   q[$];
  bit [31:0]   busy;
  int          starve;
  bit          exp_we;
  reg_idx_t    exp_reg;
  logic [31:0] exp_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model: what the write port and scoreboard must do given this edge's inputs.
  task automatic model_step();
    int sz;
    bit prdy, psel, do_pop, do_push;
    wb_entry_t h;
    if (RST) begin
      q.delete();
      busy   = '0;
      starve = 0;
      exp_we = 1'b0;
      return;
    end
    sz      = q.size();
    prdy    = (starve != STARVE);
    psel    = bus.PriValid && prdy;
    do_push = bus.SecValid && (sz < DEPTH);
    do_pop  = !psel && (sz > 0);
    if (psel) begin
      exp_we   = (bus.PriReg != 0);
      exp_reg  = bus.PriReg;
      exp_data = bus.PriData;
    end else if (do_pop) begin
      h        = q.pop_front();
      exp_we   = (h.rd != 0);
      exp_reg  = h.rd;
      exp_data = h.data;
      busy[h.rd] = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    if (do_push) q.push_back('{rd: bus.SecReg, data: bus.SecData});
    if (bus.IssueValid && bus.IssueReg != 0) busy[bus.IssueReg] = 1'b1;
    if (do_pop || sz == 0) starve = 0;
    else if (psel) starve++;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("m_RegWrite", bus.RegWrite, exp_we);
      if (exp_we) begin
        chk("m_WriteRegisterSelect", bus.WriteRegisterSelect, exp_reg);
        chk("m_WriteData", bus.WriteData, exp_data);
      end
      chk("m_FifoCount", bus.FifoCount, q.size());
      chk("m_SecReady", bus.SecReady, (q.size() < DEPTH) && !RST);
      chk("m_PriReady", bus.PriReady, starve != STARVE);
      chk("m_Hazard", bus.Hazard, busy[bus.ReadRegister1] | busy[bus.ReadRegister2]);
      chk("fifo_bound", bus.FifoCount <= DEPTH, 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    bus.PriValid = 0; bus.PriReg = 0; bus.PriData = 0;
    bus.SecValid = 0; bus.SecReg = 0; bus.SecData = 0;
    bus.IssueValid = 0; bus.IssueReg = 0;
    bus.ReadRegister1 = 0; bus.ReadRegister2 = 0;

    // 1: reset state, then a primary write
    tick();
    chk_en = 1;
    tick();
    @(negedge CLK);
    chk("rst_RegWrite", bus.RegWrite, 0);
    chk("rst_WRS", bus.WriteRegisterSelect, 0);
    chk("rst_WriteData", bus.WriteData, 0);
    chk("rst_FifoCount", bus.FifoCount, 0);
    chk("rst_SecReady", bus.SecReady, 0);
    tick();
    RST = 1'b0;
    bus.PriValid = 1; bus.PriReg = 5; bus.PriData = 32'h1234;
    tick();
    bus.PriValid = 0;
    bus.IssueValid = 1; bus.IssueReg = 7; bus.ReadRegister1 = 7;
    @(negedge CLK);
    chk("t1_RegWrite", bus.RegWrite, 1);
    chk("t1_WRS", bus.WriteRegisterSelect, 5);
    chk("t1_WriteData", bus.WriteData, 32'h1234);

    // 2: issue R7, secondary result arrives, hazard clears
    tick();
    bus.IssueValid = 0;
    bus.SecValid = 1; bus.SecReg = 7; bus.SecData = 32'hDEAD;
    @(negedge CLK);
    chk("t2_Hazard_set", bus.Hazard, 1);
    tick();
    bus.SecValid = 0;
    @(negedge CLK);
    chk("t2_FifoCount", bus.FifoCount, 1);
    chk("t2_no_bypass", bus.RegWrite, 0);
    chk("t2_Hazard_hold", bus.Hazard, 1);
    tick();
    @(negedge CLK);
    chk("t2_RegWrite", bus.RegWrite, 1);
    chk("t2_WRS", bus.WriteRegisterSelect, 7);
    chk("t2_WriteData", bus.WriteData, 32'hDEAD);
    tick();
    @(negedge CLK);
    chk("t2_Hazard_clr", bus.Hazard, 0);
    chk("t2_idle", bus.RegWrite, 0);

    // 3: starvation relief
    tick();
    bus.ReadRegister1 = 0;
    bus.PriValid = 1; bus.PriReg = 3; bus.PriData = 32'h3333;
    bus.SecValid = 1; bus.SecReg = 9; bus.SecData = 32'h9999;
    tick();
    bus.SecValid = 0;
    for (int i = 0; i < STARVE; i++) begin
      @(negedge CLK);
      chk("t3_PriReady_win", bus.PriReady, 1);
      tick();
    end
    @(negedge CLK);
    chk("t3_PriReady_held", bus.PriReady, 0);
    chk("t3_FifoCount", bus.FifoCount, 1);
    tick();
    @(negedge CLK);
    chk("t3_RegWrite", bus.RegWrite, 1);
    chk("t3_WRS", bus.WriteRegisterSelect, 9);
    chk("t3_WriteData", bus.WriteData, 32'h9999);
    chk("t3_PriReady_back", bus.PriReady, 1);
    tick();
    @(negedge CLK);
    chk("t3_pri_resume", bus.WriteRegisterSelect, 3);

    // 4: fill FIFO under primary pressure, then drain in order
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      bus.SecValid = 1; bus.SecReg = reg_idx_t'(10 + i); bus.SecData = 32'hA0 + i;
      tick();
    end
    bus.SecValid = 0;
    @(negedge CLK);
    chk("t4_FifoCount_full", bus.FifoCount, DEPTH);
    chk("t4_SecReady_full", bus.SecReady, 0);
    tick();
    bus.PriValid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      @(negedge CLK);
      chk("t4_RegWrite", bus.RegWrite, 1);
      chk("t4_WRS", bus.WriteRegisterSelect, 10 + i);
      chk("t4_WriteData", bus.WriteData, 32'hA0 + i);
    end

    // 5: register 0 on both streams and issue
    tick();
    bus.PriValid = 1; bus.PriReg = 0; bus.PriData = 32'h5555;
    bus.SecValid = 1; bus.SecReg = 0; bus.SecData = 32'h6666;
    bus.IssueValid = 1; bus.IssueReg = 0;
    tick();
    bus.PriValid = 0; bus.SecValid = 0; bus.IssueValid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t5_RegWrite_r0", bus.RegWrite, 0);
      tick();
    end
    @(negedge CLK);
    chk("t5_FifoCount", bus.FifoCount, 0);
    chk("t5_busy0", bus.Hazard, 0);

    // 6: reset mid-operation
    tick();
    bus.IssueValid = 1; bus.IssueReg = 4; bus.ReadRegister1 = 4;
    bus.PriValid = 1; bus.PriReg = 3; bus.PriData = 32'h7777;
    for (int i = 0; i < 3; i++) begin
      bus.SecValid = 1; bus.SecReg = reg_idx_t'(20 + i); bus.SecData = 32'hC0 + i;
      tick();
      bus.IssueValid = 0;
    end
    bus.SecValid = 0;
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_FifoCount_pre", bus.FifoCount, 3);
    chk("t6_Hazard_pre", bus.Hazard, 1);
    tick();
    @(negedge CLK);
    chk("t6_FifoCount_r1", bus.FifoCount, 0);
    chk("t6_Hazard_r1", bus.Hazard, 0);
    chk("t6_RegWrite_r1", bus.RegWrite, 0);
    tick();
    RST = 1'b0;
    bus.PriValid = 0;
    @(negedge CLK);
    chk("t6_FifoCount_r2", bus.FifoCount, 0);
    chk("t6_Hazard_r2", bus.Hazard, 0);
    chk("t6_RegWrite_r2", bus.RegWrite, 0);
    tick();
    @(negedge CLK);
    chk("t6_idle", bus.RegWrite, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
